bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 24 ++
 rtl/bus_arbiter_if.sv | 23 ++
 rtl/bus_arbiter_rr_sel.sv | 38 +++
 rtl/bus_arbiter.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM state encoding,
// master identifiers and a small id-to-one-hot helper.
package bus_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_GRANT1 = 2'b01;
  localparam logic [1:0] ST_GRANT2 = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    GRANT1 = ST_GRANT1,
    GRANT2 = ST_GRANT2
  } arb_state_e;

  // Master ids double as the msel encoding (0 = master 1, 1 = master 2).
  localparam logic MID_M1 = 1'b0;
  localparam logic MID_M2 = 1'b1;

  // One-hot position of a master id inside the per-master vectors.
  function automatic logic [1:0] mid_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the two bus masters and the arbiter.
// master: requester side (drives requests and split handshake).
// slave : arbiter side (drives grants, mux select and busy).
interface bus_arbiter_if;
  logic breq1;
  logic breq2;
  logic ssplit;
  logic split_done;
  logic bgrant1;
  logic bgrant2;
  logic msel;
  logic bbusy;

  modport master (
    output breq1, breq2, ssplit, split_done,
    input  bgrant1, bgrant2, msel, bbusy
  );

  modport slave (
    input  breq1, breq2, ssplit, split_done,
    output bgrant1, bgrant2, msel, bbusy
  );
endinterface

// File: rtl/bus_arbiter_rr_sel.sv
// Tie-break selector: picks the winning master among eligible requesters.
// A pending resume beats round-robin; otherwise the master that was not
// served last wins a tie.
module arb_rr_sel
  import bus_arbiter_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       last_served,
  input  logic [1:0] resume,
  output logic       winner,
  output logic       valid
);

  logic [1:0] res_elig_s;

  assign res_elig_s = resume & eligible;

  // Choose the winner from the eligible set.
  always_comb begin
    winner = MID_M1;
    valid  = |eligible;
    case (eligible)
      2'b01: winner = MID_M1;
      2'b10: winner = MID_M2;
      2'b11: begin
        if (res_elig_s == 2'b01) begin
          winner = MID_M1;
        end else if (res_elig_s == 2'b10) begin
          winner = MID_M2;
        end else begin
          winner = ~last_served;
        end
      end
      default: winner = MID_M1;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with round-robin tie-break and IDLE gap on every
// handover. Optional split-transaction support is compiled in with the
// ARB_SPLIT_EN macro; without it ssplit/split_done are ignored and the
// split state is tied to zero.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned SPLIT_HOLD_MAX = 15
)(
  input  logic          clk,
  input  logic          rstn,
  bus_arbiter_if.slave  bus
);

  arb_state_e state_r;
  logic       bgrant1_r;
  logic       bgrant2_r;
  logic       msel_r;
  logic       bbusy_r;
  logic       last_served_r;
  logic [1:0] split_r;
  logic [1:0] resume_r;
  logic [1:0] split_take_s;
  logic [1:0] elig_s;
  logic       win_s;
  logic       win_valid_s;

  assign bus.bgrant1 = bgrant1_r;
  assign bus.bgrant2 = bgrant2_r;
  assign bus.msel    = msel_r;
  assign bus.bbusy   = bbusy_r;

  // A split-parked master may not compete until its flag clears.
  assign elig_s = {bus.breq2 & ~split_r[1], bus.breq1 & ~split_r[0]};

  arb_rr_sel u_sel (
    .eligible    (elig_s),
    .last_served (last_served_r),
    .resume      (resume_r),
    .winner      (win_s),
    .valid       (win_valid_s)
  );

`ifdef ARB_SPLIT_EN
  localparam logic [3:0] HOLD_LAST_C = 4'(SPLIT_HOLD_MAX - 1);

  logic [3:0] split_cnt_r;
  logic       done_s;
  logic [1:0] grant_clr_s;

  // Split only while the owner still requests (deassert wins) and only if
  // the other master is not already parked.
  assign split_take_s[0] = (state_r == GRANT1) & bus.breq1 & bus.ssplit & ~split_r[1];
  assign split_take_s[1] = (state_r == GRANT2) & bus.breq2 & bus.ssplit & ~split_r[0];
  assign done_s          = bus.split_done & (|split_r);
  assign grant_clr_s     = ((state_r == IDLE) && win_valid_s) ? mid_onehot(win_s) : 2'b00;

  // Track split flags, their hold timeout and resume priority.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      split_r     <= 2'b00;
      resume_r    <= 2'b00;
      split_cnt_r <= 4'd0;
    end else begin
      resume_r <= (resume_r & ~grant_clr_s) | (done_s ? split_r : 2'b00);
      if (|split_take_s) begin
        split_r     <= split_r | split_take_s;
        split_cnt_r <= 4'd0;
      end else if (done_s) begin
        split_r     <= 2'b00;
        split_cnt_r <= 4'd0;
      end else if (|split_r) begin
        if (split_cnt_r == HOLD_LAST_C) begin
          split_r     <= 2'b00;
          split_cnt_r <= 4'd0;
        end else begin
          split_cnt_r <= split_cnt_r + 4'd1;
        end
      end else begin
        split_cnt_r <= 4'd0;
      end
    end
  end
`else
  logic split_unused_s;

  assign split_unused_s = ^{bus.ssplit, bus.split_done};
  assign split_take_s   = 2'b00;
  assign split_r        = 2'b00;
  assign resume_r       = 2'b00;
`endif

  // Arbitration FSM with registered grant, select and busy outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r       <= IDLE;
      bgrant1_r     <= 1'b0;
      bgrant2_r     <= 1'b0;
      msel_r        <= MID_M1;
      bbusy_r       <= 1'b0;
      last_served_r <= MID_M2;
    end else begin
      case (state_r)
        IDLE: begin
          if (win_valid_s) begin
            state_r   <= (win_s == MID_M2) ? GRANT2 : GRANT1;
            bgrant1_r <= (win_s == MID_M1);
            bgrant2_r <= (win_s == MID_M2);
            msel_r    <= win_s;
            bbusy_r   <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT1: begin
          if (!bus.breq1 || split_take_s[0]) begin
            state_r       <= IDLE;
            bgrant1_r     <= 1'b0;
            bbusy_r       <= 1'b0;
            last_served_r <= MID_M1;
          end else begin
            state_r <= GRANT1;
          end
        end
        GRANT2: begin
          if (!bus.breq2 || split_take_s[1]) begin
            state_r       <= IDLE;
            bgrant2_r     <= 1'b0;
            bbusy_r       <= 1'b0;
            last_served_r <= MID_M2;
          end else begin
            state_r <= GRANT2;
          end
        end
        default: begin
          state_r   <= IDLE;
          bgrant1_r <= 1'b0;
          bgrant2_r <= 1'b0;
          bbusy_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule
